// File: rtl/uart_rx_bit_pkg.sv
// uart_rx_bit_pkg: uart state encodings and bit-timing constants shared by the rx and tx bit engines
package uart_rx_bit_pkg;
    localparam int OVERSAMPLE = 16;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
    localparam logic [3:0] SAMP_A       = 4'd7;
    localparam logic [3:0] SAMP_B       = 4'd8;
    localparam logic [3:0] SAMP_C       = 4'd9;
    localparam logic [3:0] LAST_TICK    = 4'(OVERSAMPLE - 1);
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for asynchronous inputs, resets to the idle-high level
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_ff;
    always_ff @(posedge clk)
        r_ff <= reset ? 2'b11 : {r_ff[0], i_d};
    assign o_q = r_ff[1];
endmodule

// File: rtl/uart_rx_bit.sv
// uart_rx_bit: 16x-oversampled 8N1 receive engine with 3-sample majority vote and one-clk output strobes
module uart_rx_bit
    import uart_rx_bit_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_16x_baud_en,
    input  logic                  i_uart_rx_ser,
    output logic [DATA_WIDTH-1:0] ov_rx_data,
    output logic                  o_rx_data_valid,
    output logic                  o_frame_err
);
    logic                  w_rx_s;
    logic                  w_bit;
    logic [2:0]            r_state;
    logic [3:0]            r_cnt;
    logic [2:0]            r_bit_idx;
    logic [DATA_WIDTH-1:0] r_sh;
    logic                  r_v7;
    logic                  r_v8;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (i_uart_rx_ser),
        .o_q   (w_rx_s)
    );

    // third vote is the live sample on the cnt 9 tick
    assign w_bit = (r_v7 & r_v8) | (r_v7 & w_rx_s) | (r_v8 & w_rx_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_bit_idx       <= '0;
            r_sh            <= '0;
            r_v7            <= 1'b1;
            r_v8            <= 1'b1;
            ov_rx_data      <= '0;
            o_rx_data_valid <= 1'b0;
            o_frame_err     <= 1'b0;
        end else begin
            o_rx_data_valid <= 1'b0;
            o_frame_err     <= 1'b0;
            if (i_16x_baud_en) begin
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == SAMP_A) r_v7 <= w_rx_s;
                if (r_cnt == SAMP_B) r_v8 <= w_rx_s;
                case (r_state)
                    ST_IDLE: begin
                        // detection tick is cnt 0, so the next tick is cnt 1
                        r_cnt <= {3'b000, ~w_rx_s};
                        if (!w_rx_s) r_state <= ST_START;
                    end
                    ST_START: begin
                        if (r_cnt == SAMP_C && w_bit) r_state <= ST_IDLE;
                        else if (r_cnt == LAST_TICK) begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (r_cnt == SAMP_C) r_sh <= {w_bit, r_sh[DATA_WIDTH-1:1]};
                        if (r_cnt == LAST_TICK) begin
                            if (r_bit_idx == 3'(DATA_WIDTH - 1)) r_state <= ST_STOP;
                            else r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                    ST_STOP: begin
                        if (r_cnt == SAMP_C) begin
                            r_state         <= w_bit ? ST_IDLE : ST_WAIT_HIGH;
                            o_rx_data_valid <= w_bit;
                            o_frame_err     <= ~w_bit;
                            if (w_bit) ov_rx_data <= r_sh;
                        end
                    end
                    ST_WAIT_HIGH: if (w_rx_s) r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_bit.sv
// tb_uart_rx_bit: scoreboard bench driving 8N1 frames on a 1-in-4 clk 16x tick
module tb_uart_rx_bit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       ser = 1'b1;
    logic [7:0] ov_rx_data;
    logic       vld;
    logic       ferr;

    typedef struct {
        bit         err;
        logic [7:0] d;
        int         tk;
    } exp_t;

    exp_t       q[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         tick_cnt = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx_bit #(.DATA_WIDTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_16x_baud_en   (en),
        .i_uart_rx_ser   (ser),
        .ov_rx_data      (ov_rx_data),
        .o_rx_data_valid (vld),
        .o_frame_err     (ferr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int ph = 0;
        forever begin
            @(negedge clk);
            en = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    initial forever begin
        @(posedge clk);
        if (en) tick_cnt++;
    end

    // pulses land 154 ticks after the tick preceding the start edge
    initial forever begin
        @(negedge clk);
        if (vld || ferr) begin
            if (q.size() == 0) chk("spurious", {vld, ferr}, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("kind", {vld, ferr}, e.err ? 2'b01 : 2'b10);
                chk("data", ov_rx_data, e.err ? last_good : e.d);
                chk("latency", tick_cnt - e.tk, 154);
                if (!e.err) last_good = e.d;
            end
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!en);
        end
        #1;
    endtask

    task automatic drive_bit(input logic v, input bit inv8);
        ser = v;
        if (inv8) begin
            wait_ticks(8);
            ser = ~v;
            wait_ticks(1);
            ser = v;
            wait_ticks(7);
        end else wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input bit inv8, input bit abort);
        if (!abort) q.push_back('{err: !stop, d: d, tk: tick_cnt});
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (abort && i == 4) begin
                ser = d[i];
                wait_ticks(8);
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                last_good = 8'h00;
                chk("rst_data", ov_rx_data, 0);
                chk("rst_flags", {vld, ferr}, 0);
                wait_ticks(8);
            end else drive_bit(d[i], inv8);
        end
        drive_bit(stop, 1'b0);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_data", ov_rx_data, 0);
        chk("reset_valid", vld, 0);
        chk("reset_err", ferr, 0);
        wait_ticks(20);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        wait_ticks(10);
        ser = 1'b0;
        wait_ticks(5);
        ser = 1'b1;
        wait_ticks(30);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        wait_ticks(10);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        wait_ticks(40);
        ser = 1'b1;
        wait_ticks(20);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        wait_ticks(10);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        wait_ticks(10);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        wait_ticks(20);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        wait_ticks(10);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4000 && q.size() != 0; i++) @(posedge clk);
        wait_ticks(200);
        chk("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
